// File: rtl/fetch_if.sv
// Bus bundle between the program sequencer and its environment: imem
// address/data, decoded instruction fields, the data-memory request pair,
// and the sequencer control/status lines.
//
// Handshake: mem_req is a level request raised by the sequencer for a
// LOAD/STORE and held until a cycle in which mem_ack is high; that cycle
// completes the transfer, and mem_req is low from the next cycle on.
// mem_ack may already be high in the first mem_req cycle, which gives a
// zero-wait transfer. mem_ack is ignored while mem_req is low.
interface fetch_if #(
  parameter int PC_W = 8,
  parameter int OP_W = 16
);
  logic            start;
  logic [OP_W-1:0] op;
  logic            cmp_flag;
  logic            mem_ack;
  logic [PC_W-1:0] pc;
  logic [3:0]      opcode;
  logic [3:0]      dst;
  logic [3:0]      src1;
  logic [3:0]      src0;
  logic [7:0]      imm;
  logic            exec_en;
  logic            mem_req;
  logic            halted;
  logic [2:0]      state_dbg;

  // Sequencer side
  modport master (
    input  start, op, cmp_flag, mem_ack,
    output pc, opcode, dst, src1, src0, imm, exec_en, mem_req, halted,
           state_dbg
  );

  // Environment side: imem, ALU flag, data memory, control
  modport slave (
    output start, op, cmp_flag, mem_ack,
    input  pc, opcode, dst, src1, src0, imm, exec_en, mem_req, halted,
           state_dbg
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Program sequencer: drives pc into imem, latches the returned op into an
// instruction register, presents decoded fields with a one-cycle exec_en
// strobe, resolves JMP/JNZ/JNO against the ALU compare flag, holds LOAD/STORE
// on the data-memory req/ack pair and halts on an unconditional jump-to-self.
// Opcode values mirror the shared instruction-set header (def.h).
module fetch_ctrl #(
  parameter int          PC_W   = 8,
  parameter int          OP_W   = 16,
  parameter int unsigned RST_PC = 0
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);

  // Opcode map (ir[15:12]) shared with the assembler
  localparam logic [3:0] OPC_RTX0  = 4'h0;
  localparam logic [3:0] OPC_LOAD  = 4'h1;
  localparam logic [3:0] OPC_STORE = 4'h2;
  localparam logic [3:0] OPC_COMP  = 4'h3;
  localparam logic [3:0] OPC_CHECK = 4'h4;
  localparam logic [3:0] OPC_JMP   = 4'h8;
  localparam logic [3:0] OPC_JNZ   = 4'h9;
  localparam logic [3:0] OPC_JNO   = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEMW  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [OP_W-1:0] ir_q, ir_d;

  logic [3:0]      opc;
  logic [7:0]      imm8;
  logic [PC_W-1:0] imm_pc;
  logic [PC_W-1:0] pc_inc;
  logic            exec_en;
  logic            mem_req;
  logic            halted;

  // Field extraction from the instruction register
  assign opc    = ir_q[15:12];
  assign imm8   = ir_q[7:0];
  assign imm_pc = PC_W'(imm8);
  // Natural wrap of the adder gives 2**PC_W-1 -> 0
  assign pc_inc = pc_q + PC_W'(1);

  // State, pc and instruction register; reset drops every output at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC_W'(RST_PC);
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, next-pc and strobe generation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    exec_en = 1'b0;
    mem_req = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // start only matters here; holding it high elsewhere is harmless
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        // imem is combinational from pc, so op is valid by the end of cycle
        ir_d    = bus.op;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        exec_en = 1'b1;
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (opc)
          OPC_JMP: begin
            // Only an unconditional jump to itself stops the program
            if (imm_pc == pc_q) begin
              pc_d    = pc_q;
              state_d = S_HALT;
            end else begin
              pc_d = imm_pc;
            end
          end
          OPC_JNZ: begin
            if (bus.cmp_flag) pc_d = imm_pc;
          end
          OPC_JNO: begin
            if (!bus.cmp_flag) pc_d = imm_pc;
          end
          OPC_LOAD, OPC_STORE: begin
            mem_req = 1'b1;
            if (!bus.mem_ack) begin
              pc_d    = pc_q;
              state_d = S_MEMW;
            end
          end
          // RTX0/COMP/CHECK and unassigned codes are plain fall-through ops
          OPC_RTX0, OPC_COMP, OPC_CHECK: ;
          default: ;
        endcase
      end
      S_MEMW: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output drive: decoded fields always reflect the instruction register
  assign bus.pc        = pc_q;
  assign bus.opcode    = ir_q[15:12];
  assign bus.dst       = ir_q[11:8];
  assign bus.src1      = ir_q[7:4];
  assign bus.src0      = ir_q[3:0];
  assign bus.imm       = imm8;
  assign bus.exec_en   = exec_en;
  assign bus.mem_req   = mem_req;
  assign bus.halted    = halted;
  assign bus.state_dbg = state_q;

endmodule
